// File: rtl/bilinear_interp_seq.sv
// Sequential bilinear interpolation core with one shared multiplier.
// The FSM walks IDLE -> T0 -> T1 -> B0 -> B1 -> V0 -> V1 -> DONE.
// It blends the two rows horizontally and then blends the two row results
// vertically. The result is rounded half-up and saturated.
module bilinear_interp_seq #(
   parameter int PIX_W     = 8,
   parameter int FRAC_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PIX_W-1:0]     p00,
   input  logic [PIX_W-1:0]     p01,
   input  logic [PIX_W-1:0]     p10,
   input  logic [PIX_W-1:0]     p11,
   input  logic [FRAC_BITS:0]   ax,
   input  logic [FRAC_BITS:0]   ay,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PIX_W-1:0]     out_pix,
   output logic                 busy
);

   localparam int H_W = PIX_W + FRAC_BITS;          // horizontal partial, UQ(PIX_W).(FRAC_BITS)
   localparam int W_W = FRAC_BITS + 1;              // weight width, holds 0..ONE
   localparam int A_W = PIX_W + 2 * FRAC_BITS;      // vertical accumulator width
   localparam int P_W = H_W + W_W;                  // multiplier product width
   localparam int R_W = P_W + 1 - 2 * FRAC_BITS;    // rounded result width before saturation

   localparam logic [W_W-1:0]   ONE     = {1'b1, {FRAC_BITS{1'b0}}};
   localparam logic [P_W:0]     HALF    = {{(PIX_W + 2){1'b0}}, 1'b1, {(2 * FRAC_BITS - 1){1'b0}}};
   localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_B0   = 3'd3,
      S_B1   = 3'd4,
      S_V0   = 3'd5,
      S_V1   = 3'd6,
      S_DONE = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic [PIX_W-1:0] p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
   logic [W_W-1:0]   ax_q, ax_d, ay_q, ay_d;
   logic [A_W-1:0]   acc_q, acc_d;
   logic [H_W-1:0]   h_top_q, h_top_d, h_bot_q, h_bot_d;
   logic [PIX_W-1:0] out_pix_q, out_pix_d;
   logic             out_valid_q, out_valid_d;

   logic [H_W-1:0]   mul_a_s;
   logic [W_W-1:0]   mul_b_s;
   logic [P_W-1:0]   prod_s;
   logic [P_W:0]     sum_s;
   logic [R_W-1:0]   r_s;
   logic [W_W-1:0]   ax_c_s, ay_c_s;

   // Shared multiplier: select one operand pair per compute state.
   always_comb begin
      mul_a_s = '0;
      mul_b_s = '0;
      case (state_q)
         S_T0:    begin mul_a_s = H_W'(p00_q); mul_b_s = ONE - ax_q; end
         S_T1:    begin mul_a_s = H_W'(p01_q); mul_b_s = ax_q;       end
         S_B0:    begin mul_a_s = H_W'(p10_q); mul_b_s = ONE - ax_q; end
         S_B1:    begin mul_a_s = H_W'(p11_q); mul_b_s = ax_q;       end
         S_V0:    begin mul_a_s = h_top_q;     mul_b_s = ONE - ay_q; end
         S_V1:    begin mul_a_s = h_bot_q;     mul_b_s = ay_q;       end
         default: begin mul_a_s = '0;          mul_b_s = '0;         end
      endcase
      prod_s = P_W'(mul_a_s) * P_W'(mul_b_s);
      sum_s  = {1'b0, {(P_W - A_W){1'b0}}, acc_q} + {1'b0, prod_s} + HALF;
      r_s    = R_W'(sum_s >> (2 * FRAC_BITS));
      ax_c_s = (ax > ONE) ? ONE : ax;
      ay_c_s = (ay > ONE) ? ONE : ay;
   end

   // Next-state and datapath updates for the interpolation FSM.
   always_comb begin
      state_d     = state_q;
      p00_d       = p00_q;
      p01_d       = p01_q;
      p10_d       = p10_q;
      p11_d       = p11_q;
      ax_d        = ax_q;
      ay_d        = ay_q;
      acc_d       = acc_q;
      h_top_d     = h_top_q;
      h_bot_d     = h_bot_q;
      out_pix_d   = out_pix_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            out_valid_d = 1'b0;
            if (in_valid) begin
               p00_d   = p00;
               p01_d   = p01;
               p10_d   = p10;
               p11_d   = p11;
               ax_d    = ax_c_s;
               ay_d    = ay_c_s;
               state_d = S_T0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_T0: begin
            acc_d   = A_W'(prod_s);
            state_d = S_T1;
         end
         S_T1: begin
            h_top_d = acc_q[H_W-1:0] + prod_s[H_W-1:0];
            state_d = S_B0;
         end
         S_B0: begin
            acc_d   = A_W'(prod_s);
            state_d = S_B1;
         end
         S_B1: begin
            h_bot_d = acc_q[H_W-1:0] + prod_s[H_W-1:0];
            state_d = S_V0;
         end
         S_V0: begin
            acc_d   = A_W'(prod_s);
            state_d = S_V1;
         end
         S_V1: begin
            // Saturation cannot trigger with clamped weights; kept as a guard.
            if (|r_s[R_W-1:PIX_W]) begin
               out_pix_d = PIX_MAX;
            end else begin
               out_pix_d = r_s[PIX_W-1:0];
            end
            out_valid_d = 1'b0;
            state_d     = S_DONE;
         end
         S_DONE: begin
            // out_valid rises one cycle into DONE, so the result appears 7 edges after accept.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. The asynchronous reset discards any in-flight tuple.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         p00_q       <= '0;
         p01_q       <= '0;
         p10_q       <= '0;
         p11_q       <= '0;
         ax_q        <= '0;
         ay_q        <= '0;
         acc_q       <= '0;
         h_top_q     <= '0;
         h_bot_q     <= '0;
         out_pix_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         p00_q       <= p00_d;
         p01_q       <= p01_d;
         p10_q       <= p10_d;
         p11_q       <= p11_d;
         ax_q        <= ax_d;
         ay_q        <= ay_d;
         acc_q       <= acc_d;
         h_top_q     <= h_top_d;
         h_bot_q     <= h_bot_d;
         out_pix_q   <= out_pix_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign out_pix   = out_pix_q;

endmodule

// File: tb/tb_bilinear_interp_seq.sv
// Self-checking bench for bilinear_interp_seq.
// Expected pixels are queued when a tuple is accepted and compared when the result appears.
module tb_bilinear_interp_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, busy;
   logic [7:0] p00 = 8'd0, p01 = 8'd0, p10 = 8'd0, p11 = 8'd0;
   logic [7:0] out_pix;
   logic [8:0] ax = 9'd0, ay = 9'd0;

   int total = 0;
   int bad = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   bilinear_interp_seq #(.PIX_W(8), .FRAC_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .p00(p00), .p01(p01), .p10(p10), .p11(p11), .ax(ax), .ay(ay),
      .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .busy(busy)
   );

   // Reference: clamp weights, blend rows, blend vertically, round half-up, saturate.
   function automatic int model(int a00, int a01, int a10, int a11, int wx, int wy);
      longint ht, hb, v;
      int r;
      if (wx > 256) wx = 256;
      if (wy > 256) wy = 256;
      ht = longint'(a00) * (256 - wx) + longint'(a01) * wx;
      hb = longint'(a10) * (256 - wx) + longint'(a11) * wx;
      v  = ht * (256 - wy) + hb * wy;
      r  = int'((v + 32768) >> 16);
      if (r > 255) r = 255;
      return r;
   endfunction

   // Present a tuple and hold it until it is accepted; ends 1 time unit after the accept edge.
   task automatic send(input int a00, input int a01, input int a10, input int a11,
                       input int wx, input int wy, output bit ok);
      int n;
      @(negedge clk);
      p00 = 8'(a00); p01 = 8'(a01); p10 = 8'(a10); p11 = 8'(a11);
      ax = 9'(wx); ay = 9'(wy);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = in_ready;
      if (ok) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   // Wait for out_valid, count edges since accept, then complete the handshake.
   task automatic recv(output int pix, output int lat, output bit got);
      got = 1'b0;
      lat = 0;
      pix = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) got = 1'b1;
      end
      pix = int'(out_pix);
      if (got) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (out_valid !== 1'b0 || out_pix !== 8'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: valid=%b pix=%0d busy=%b required 0/0/0", out_valid, out_pix, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_corners();
      int tab[7][7] = '{
         '{37, 200, 200, 200, 0, 0, 37},
         '{0, 99, 0, 0, 256, 0, 99},
         '{0, 0, 11, 0, 0, 256, 11},
         '{0, 0, 0, 250, 256, 256, 250},
         '{0, 255, 0, 255, 128, 128, 128},
         '{255, 255, 255, 255, 77, 201, 255},
         '{10, 60, 0, 0, 300, 0, 60}
      };
      bit ok, got;
      int pix, lat, e;
      for (int i = 0; i < 7; i++) begin
         send(tab[i][0], tab[i][1], tab[i][2], tab[i][3], tab[i][4], tab[i][5], ok);
         if (ok) exp_q.push_back(tab[i][6]);
         recv(pix, lat, got);
         total++;
         if (!ok || !got) begin
            bad++;
            $display("FAIL corner%0d_timeout: accepted=%b produced=%b required 1/1", i, ok, got);
         end else begin
            e = exp_q.pop_front();
            if (pix !== e) begin
               bad++;
               $display("FAIL corner%0d_pix: got %0d required %0d", i, pix, e);
            end
            if (i == 0) begin
               total++;
               if (lat !== 7) begin
                  bad++;
                  $display("FAIL latency: got %0d edges required 7", lat);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok, got;
      int held;
      send(20, 40, 60, 80, 64, 192, ok);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) got = 1'b1;
      end
      held = int'(out_pix);
      total++;
      if (!ok || !got || held !== model(20, 40, 60, 80, 64, 192)) begin
         bad++;
         $display("FAIL bp_result: pix=%0d produced=%b required %0d", held, got,
                  model(20, 40, 60, 80, 64, 192));
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (out_valid !== 1'b1 || int'(out_pix) !== held || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: valid=%b pix=%0d in_ready=%b required 1/%0d/0",
                     i, out_valid, out_pix, in_ready, held);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, got;
      int pix, lat, e, stale;
      send(100, 150, 200, 250, 100, 100, ok);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (!ok || busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy: busy=%b accepted=%b required 1/1", busy, ok);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_pix !== 8'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_outputs: valid=%b pix=%0d busy=%b required 0/0/0", out_valid, out_pix, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) stale++;
      end
      total++;
      if (stale !== 0) begin
         bad++;
         $display("FAIL mid_stale_valid: got %0d cycles required 0", stale);
      end
      send(90, 30, 210, 5, 33, 170, ok);
      if (ok) exp_q.push_back(model(90, 30, 210, 5, 33, 170));
      recv(pix, lat, got);
      total++;
      if (!ok || !got) begin
         bad++;
         $display("FAIL mid_next_timeout: accepted=%b produced=%b required 1/1", ok, got);
      end else begin
         e = exp_q.pop_front();
         if (pix !== e) begin
            bad++;
            $display("FAIL mid_next_pix: got %0d required %0d", pix, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok, got;
      int a[4], wx, wy, pix, lat, e;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 4; j++) a[j] = int'($urandom_range(0, 255));
         wx = int'($urandom_range(0, 300));
         wy = int'($urandom_range(0, 300));
         send(a[0], a[1], a[2], a[3], wx, wy, ok);
         if (ok) exp_q.push_back(model(a[0], a[1], a[2], a[3], wx, wy));
         // Scramble the ports while busy; the captured tuple must be used.
         p00 = 8'($urandom); p01 = 8'($urandom); p10 = 8'($urandom); p11 = 8'($urandom);
         ax = 9'($urandom); ay = 9'($urandom);
         recv(pix, lat, got);
         total++;
         if (!ok || !got) begin
            bad++;
            $display("FAIL b2b%0d_timeout: accepted=%b produced=%b required 1/1", k, ok, got);
         end else begin
            e = exp_q.pop_front();
            if (pix !== e) begin
               bad++;
               $display("FAIL b2b%0d_pix: got %0d required %0d", k, pix, e);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_corners();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
